// File: rtl/dfh_chain_walker.sv
// dfh_chain_walker: follows a DFH linked list over a 64-bit MMIO read port
// and streams one record per discovered header.
module dfh_chain_walker #(
    parameter int ADDR_W         = 20,
    parameter int MAX_FEATURES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        feat_count,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [63:0]       rd_rsp_data,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [63:0]       rec_dfh,
    output logic [7:0]        rec_idx
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = ((ADDR_W > 24) ? ADDR_W : 24) + 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [63:0]       hdr;
    logic [7:0]        cnt;
    logic [TW-1:0]     tmo;
    logic [1:0]        code;
    logic              err_q;

    logic [23:0]       nxt_off;
    logic              eol;
    logic [SW-1:0]     sum;
    logic              ovf;
    logic [7:0]        cnt_inc;

    assign nxt_off = hdr[39:16];
    assign eol     = hdr[40];
    assign sum     = SW'(cur_addr) + SW'(nxt_off);
    assign ovf     = |sum[SW-1:ADDR_W];
    assign cnt_inc = cnt + 8'd1;

    // err is raised on the transition into FIN so it is visible with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            hdr      <= '0;
            cnt      <= '0;
            tmo      <= '0;
            code     <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr <= {base_addr[ADDR_W-1:3], 3'b000};
                        cnt      <= '0;
                        code     <= 2'd0;
                        err_q    <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rd_req_ready) begin
                        tmo   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rd_rsp_valid) begin
                        hdr   <= rd_rsp_data;
                        state <= S_EMIT;
                    end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        code  <= 2'd1;
                        err_q <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        cnt <= cnt_inc;
                        if (eol || nxt_off == 24'd0) begin
                            state <= S_FIN;
                        end else if (cnt_inc == 8'(MAX_FEATURES)) begin
                            code  <= 2'd2;
                            err_q <= 1'b1;
                            state <= S_FIN;
                        end else if (ovf) begin
                            code  <= 2'd3;
                            err_q <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            cur_addr <= sum[ADDR_W-1:0];
                            state    <= S_REQ;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state == S_REQ) || (state == S_WAIT) ||
                          (state == S_EMIT);
    assign done         = (state == S_FIN);
    assign err          = err_q;
    assign err_code     = code;
    assign feat_count   = cnt;
    assign rd_req_valid = (state == S_REQ);
    assign rd_req_addr  = {cur_addr[ADDR_W-1:3], 3'b000};
    assign rec_valid    = (state == S_EMIT);
    assign rec_addr     = cur_addr;
    assign rec_dfh      = hdr;
    assign rec_idx      = cnt;

endmodule

// File: tb/tb_dfh_chain_walker.sv
// tb_dfh_chain_walker: scoreboard bench; stimulus pushes expected records
// and walk outcomes, a negedge monitor pops and compares them.
module tb_dfh_chain_walker;
    localparam int AW = 20;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [63:0]   dfh;
        logic [7:0]    idx;
        logic          last;
    } rec_t;

    typedef struct packed {
        logic       err;
        logic [1:0] code;
        logic [7:0] cnt;
        int         tmo;
    } fin_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    feat_count;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_rsp_valid;
    logic [63:0]   rd_rsp_data;
    logic          rec_valid;
    logic          rec_ready;
    logic [AW-1:0] rec_addr;
    logic [63:0]   rec_dfh;
    logic [7:0]    rec_idx;
    logic [126:0]  outs;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int done_cnt = 0;
    int stall_seen = 0;
    int stall_left = 0;
    int stall_idx = 1;
    int rsp_delay = 1;
    logic silent = 1'b0;

    logic [63:0] mem [int];
    rec_t exp_q [$];
    fin_t done_q [$];

    dfh_chain_walker #(
        .ADDR_W(AW),
        .MAX_FEATURES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .busy(busy),
        .done(done),
        .err(err),
        .err_code(err_code),
        .feat_count(feat_count),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_data(rd_rsp_data),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_addr(rec_addr),
        .rec_dfh(rec_dfh),
        .rec_idx(rec_idx)
    );

    assign outs = {busy, done, err, err_code, feat_count, rd_req_valid,
                   rd_req_addr, rec_valid, rec_addr, rec_dfh, rec_idx};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mk(input logic [3:0] ft,
                                       input logic [18:0] rsv,
                                       input logic e,
                                       input logic [23:0] off,
                                       input logic [3:0] maj,
                                       input logic [11:0] id);
        return {ft, rsv, e, off, maj, id};
    endfunction

    task automatic push_rec(input logic [AW-1:0] a, input logic [63:0] d,
                            input logic [7:0] i, input logic l);
        rec_t r;
        r.addr = a; r.dfh = d; r.idx = i; r.last = l;
        exp_q.push_back(r);
    endtask

    task automatic push_fin(input logic e, input logic [1:0] c,
                            input logic [7:0] n, input int t);
        fin_t f;
        f.err = e; f.code = c; f.cnt = n; f.tmo = t;
        done_q.push_back(f);
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        base_addr = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || rd_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL start_latency busy=%b rd_req_valid=%b want 1/1",
                     busy, rd_req_valid);
        end
    endtask

    task automatic wait_done(input int lim);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < lim) begin
            @(posedge clk);
            k++;
        end
        vectors++;
        if (done_cnt == d0) begin
            miscompares++;
            $display("FAIL done_timeout no done within %0d cycles", lim);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL records_missing got %0d left want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // Memory-backed responder; one response rsp_delay cycles after a request.
    initial begin : responder
        logic [AW-1:0] a;
        rd_req_ready = 1'b1;
        rd_rsp_valid = 1'b0;
        rd_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (rd_req_valid && rd_req_ready && rst_n) begin
                a = rd_req_addr;
                repeat (rsp_delay) @(posedge clk);
                #1;
                if (!silent) begin
                    rd_rsp_valid = 1'b1;
                    rd_rsp_data = mem.exists(int'(a)) ? mem[int'(a)] : 64'd0;
                end
                @(posedge clk); #1;
                rd_rsp_valid = 1'b0;
                rd_rsp_data = '0;
            end
        end
    end

    initial begin : sink
        rec_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rec_valid && int'(rec_idx) == stall_idx && stall_left > 0) begin
                rec_ready = 1'b0;
                stall_left--;
            end else begin
                rec_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        rec_t e;
        fin_t f;
        logic chk_next;
        logic exp_last;
        chk_next = 1'b0;
        exp_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_next = 1'b0;
            end else begin
                if (chk_next) begin
                    chk_next = 1'b0;
                    vectors++;
                    if (exp_last ? (done !== 1'b1) : (rd_req_valid !== 1'b1)) begin
                        miscompares++;
                        $display("FAIL post_handshake done=%b rd_req_valid=%b last=%b",
                                 done, rd_req_valid, exp_last);
                    end
                end
                if (rd_req_valid && rd_req_ready) hs_cyc = cyc;
                if (rec_valid) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rec_unexpected addr=%h idx=%0d", rec_addr, rec_idx);
                    end else begin
                        e = exp_q[0];
                        if (rec_addr !== e.addr || rec_dfh !== e.dfh ||
                            rec_idx !== e.idx) begin
                            miscompares++;
                            $display("FAIL rec_payload got %h/%h/%0d want %h/%h/%0d",
                                     rec_addr, rec_dfh, rec_idx, e.addr, e.dfh, e.idx);
                        end
                        if (!rec_ready) begin
                            stall_seen++;
                            vectors++;
                            if (rd_req_valid !== 1'b0) begin
                                miscompares++;
                                $display("FAIL stall_req rd_req_valid=%b want 0",
                                         rd_req_valid);
                            end
                        end else begin
                            void'(exp_q.pop_front());
                            chk_next = 1'b1;
                            exp_last = e.last;
                        end
                    end
                end
                if (done) begin
                    vectors++;
                    done_cnt++;
                    if (done_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL done_unexpected err_code=%0d", err_code);
                    end else begin
                        f = done_q.pop_front();
                        if ({err, err_code, feat_count, busy} !==
                            {f.err, f.code, f.cnt, 1'b0}) begin
                            miscompares++;
                            $display("FAIL done_status got err=%b code=%0d cnt=%0d busy=%b want %b/%0d/%0d/0",
                                     err, err_code, feat_count, busy,
                                     f.err, f.code, f.cnt);
                        end
                        if (f.tmo != 0) begin
                            vectors++;
                            if (cyc - hs_cyc != f.tmo) begin
                                miscompares++;
                                $display("FAIL done_latency got %0d want %0d",
                                         cyc - hs_cyc, f.tmo);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] d;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // three-header chain with a 5-cycle stall on record 1
        d = mk(4'h3, 19'h5A5A5, 1'b0, 24'h001000, 4'h2, 12'h0A1);
        mem[32'h00000] = d; push_rec(20'h00000, d, 8'd0, 1'b0);
        d = mk(4'hC, 19'h12345, 1'b0, 24'h002000, 4'h7, 12'hF0F);
        mem[32'h01000] = d; push_rec(20'h01000, d, 8'd1, 1'b0);
        d = mk(4'h1, 19'h7FFFF, 1'b1, 24'h000055, 4'hE, 12'h123);
        mem[32'h03000] = d; push_rec(20'h03000, d, 8'd2, 1'b1);
        push_fin(1'b0, 2'd0, 8'd3, 0);
        stall_idx = 1;
        stall_left = 5;
        stall_seen = 0;
        do_start(20'h00000);
        wait_done(200);
        vectors++;
        if (stall_seen != 5) begin
            miscompares++;
            $display("FAIL stall_cycles got %0d want 5", stall_seen);
        end

        // silent responder
        silent = 1'b1;
        push_fin(1'b1, 2'd1, 8'd0, 17);
        do_start(20'h04000);
        wait_done(100);
        silent = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (err !== 1'b1 || err_code !== 2'd1) begin
            miscompares++;
            $display("FAIL err_hold got %b/%0d want 1/1", err, err_code);
        end

        // chain longer than MAX_FEATURES
        for (int i = 0; i < 4; i++) begin
            d = mk(4'h2, 19'h0, 1'b0, 24'h000100, 4'h0, 12'(i));
            mem[32'h08000 + i * 32'h100] = d;
            push_rec(20'h08000 + 20'(i * 32'h100), d, 8'(i), i == 3);
        end
        push_fin(1'b1, 2'd2, 8'd4, 0);
        do_start(20'h08000);
        wait_done(200);

        // zero offset ends the chain; unaligned base is forced to 8 bytes
        d = mk(4'h5, 19'h0, 1'b0, 24'h000000, 4'h1, 12'h777);
        mem[32'h09000] = d; push_rec(20'h09000, d, 8'd0, 1'b1);
        push_fin(1'b0, 2'd0, 8'd1, 0);
        do_start(20'h09005);
        wait_done(100);

        // next address carries out of 20 bits
        d = mk(4'h6, 19'h0, 1'b0, 24'h002000, 4'h3, 12'h0FE);
        mem[32'hFF000] = d; push_rec(20'hFF000, d, 8'd0, 1'b1);
        push_fin(1'b1, 2'd3, 8'd1, 0);
        do_start(20'hFF000);
        wait_done(100);

        // reset while waiting, then a late response
        mem[32'h0A000] = mk(4'h9, 19'h0, 1'b1, 24'h0, 4'h0, 12'h1);
        rsp_delay = 3;
        do_start(20'h0A000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL midwalk_reset got %h want 0", outs);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL late_rsp_ignored got %h want 0", outs);
        end
        rsp_delay = 1;

        d = mk(4'hA, 19'h00ABC, 1'b0, 24'h000040, 4'h4, 12'h321);
        mem[32'h0B000] = d; push_rec(20'h0B000, d, 8'd0, 1'b0);
        d = mk(4'hB, 19'h0, 1'b1, 24'h000000, 4'h5, 12'h654);
        mem[32'h0B040] = d; push_rec(20'h0B040, d, 8'd1, 1'b1);
        push_fin(1'b0, 2'd0, 8'd2, 0);
        do_start(20'h0B000);
        wait_done(100);

        repeat (3) @(posedge clk);
        vectors++;
        if (done_q.size() != 0) begin
            miscompares++;
            $display("FAIL done_missing got %0d left want 0", done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
